// File: rtl/mem_stage.sv
// MEM stage of core_lapido: data-memory req/ack access with stall, branch redirect, EX/MEM
// forwarding and the MEM/WB register. Optional access timeout under MEM_STAGE_TIMEOUT_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 16
`endif
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 16
`endif
`ifndef GRP_ADDR_WIDTH
`define GRP_ADDR_WIDTH 5
`endif
`ifndef WB_RES_ALU
`define WB_RES_ALU 2'd0
`endif
`ifndef WB_RES_MEM
`define WB_RES_MEM 2'd1
`endif
`ifndef WB_RES_IMM
`define WB_RES_IMM 2'd2
`endif
`ifndef WB_RES_PC
`define WB_RES_PC 2'd3
`endif

module mem_stage #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned PC_W           = `PC_WIDTH,
    parameter int unsigned ADDR_W         = `DATA_MEM_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_mem_write_enable,
    input  logic [1:0]                 in_wb_res_mux,
    input  logic                       in_reg_write_enable,
    input  logic [`GRP_ADDR_WIDTH-1:0] in_reg_dest,
    input  logic [DATA_W-1:0]          in_alu_res,
    input  logic [DATA_W-1:0]          in_imm,
    input  logic [PC_W-1:0]            in_next_pc,
    input  logic [PC_W-1:0]            in_branch_addr,
    input  logic [ADDR_W-1:0]          in_mem_addr,
    input  logic [DATA_W-1:0]          in_mem_data,
    input  logic                       in_branch_taken,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [ADDR_W-1:0]          dmem_addr,
    output logic [DATA_W-1:0]          dmem_wdata,
    input  logic                       dmem_ack,
    input  logic [DATA_W-1:0]          dmem_rdata,
    output logic                       stall,
    output logic                       branch_taken,
    output logic [PC_W-1:0]            branch_addr,
    output logic [DATA_W-1:0]          fwd_data,
    output logic [1:0]                 out_wb_res_mux,
    output logic                       out_reg_write_enable,
    output logic [`GRP_ADDR_WIDTH-1:0] out_reg_dest,
    output logic [DATA_W-1:0]          out_alu_res,
    output logic [DATA_W-1:0]          out_mem_rdata,
    output logic [PC_W-1:0]            out_next_pc,
    output logic [DATA_W-1:0]          out_imm,
    output logic                       mem_error
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic                req_we_q;
    logic                load;
    logic                mem_op;
    logic                timeout;

    assign load   = in_reg_write_enable && (in_wb_res_mux == `WB_RES_MEM);
    assign mem_op = in_mem_write_enable || load;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CntW-1:0] cnt_q;
    logic            mem_error_q;

    // Counter sits at zero in IDLE so it is already clear on entry to WAIT.
    assign timeout = (state_q == StWait) && !dmem_ack && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            cnt_q       <= (state_q == StWait && !timeout) ? cnt_q + CntW'(1) : '0;
            mem_error_q <= mem_error_q | timeout;
        end
    end

    assign mem_error = mem_error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
    assign mem_error      = 1'b0;
`endif

    // Reset gates every combinational output so an abandoned access drops at once.
    always_comb begin
        stall        = rst && mem_op && !dmem_ack && !timeout;
        branch_taken = rst && in_branch_taken && !stall;
        branch_addr  = rst ? in_branch_addr : '0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        fwd_data     = '0;
        if (rst) begin
            if (state_q == StWait) begin
                dmem_req   = !timeout;
                dmem_we    = req_we_q && !timeout;
                dmem_addr  = req_addr_q;
                dmem_wdata = req_wdata_q;
            end else begin
                dmem_req   = mem_op;
                dmem_we    = in_mem_write_enable;
                dmem_addr  = in_mem_addr;
                dmem_wdata = in_mem_data;
            end
            case (in_wb_res_mux)
                `WB_RES_PC:  fwd_data = DATA_W'(in_next_pc);
                `WB_RES_IMM: fwd_data = in_imm;
                default:     fwd_data = in_alu_res;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mem_op && !dmem_ack) begin
                        req_addr_q  <= in_mem_addr;
                        req_wdata_q <= in_mem_data;
                        req_we_q    <= in_mem_write_enable;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (dmem_ack || timeout) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wb_res_mux       <= '0;
            out_reg_write_enable <= 1'b0;
            out_reg_dest         <= '0;
            out_alu_res          <= '0;
            out_mem_rdata        <= '0;
            out_next_pc          <= '0;
            out_imm              <= '0;
        end else if (stall) begin
            out_wb_res_mux       <= '0;
            out_reg_write_enable <= 1'b0;
        end else begin
            out_wb_res_mux       <= in_wb_res_mux;
            out_reg_write_enable <= in_reg_write_enable && !in_mem_write_enable && !timeout;
            out_reg_dest         <= in_reg_dest;
            out_alu_res          <= in_alu_res;
            out_next_pc          <= in_next_pc;
            out_imm              <= in_imm;
            if (load && dmem_ack) out_mem_rdata <= dmem_rdata;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the core_lapido five-stage pipeline. It sits between the EX/MEM pipeline register and the write-back stage. It issues loads and stores to the data memory over a req/ack handshake and stalls the front of the pipeline while an access is outstanding. It also resolves branch redirects toward fetch, forwards the EX/MEM result back to the EX operand muxes, and registers the MEM/WB field.

## Interface
- DATA_W, 32, GPR and data-memory word width
- PC_W, `PC_WIDTH, program-counter width
- ADDR_W, `DATA_MEM_ADDR_WIDTH, data-memory address width
- TIMEOUT_CYCLES, 255, wait limit used only under MEM_STAGE_TIMEOUT_EN
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_mem_write_enable  in  1  store request from EX/MEM
- in_wb_res_mux  in  2  WB source select; load ⇔ in_reg_write_enable && in_wb_res_mux==`WB_RES_MEM
- in_reg_write_enable  in  1  register-file write enable
- in_reg_dest  in  `GRP_ADDR_WIDTH  destination register
- in_alu_res / in_imm  in  DATA_W  ALU result / immediate
- in_next_pc / in_branch_addr  in  PC_W  pc+1 / branch target
- in_mem_addr / in_mem_data  in  ADDR_W / DATA_W  access address / store data
- in_branch_taken  in  1  branch resolved taken in EX
- dmem_req / dmem_we  out  1  access request / write strobe
- dmem_addr / dmem_wdata  out  ADDR_W / DATA_W  access address / store data
- dmem_ack  in  1  access complete this cycle; dmem_rdata valid with it
- dmem_rdata  in  DATA_W  load data
- stall  out  1  hold IF/ID/EX registers
- branch_taken / branch_addr  out  1 / PC_W  redirect and flush to IF, ID, EX
- fwd_data  out  DATA_W  EX_MEM_data forwarding value
- out_wb_res_mux, out_reg_write_enable, out_reg_dest, out_alu_res, out_mem_rdata, out_next_pc, out_imm  out  MEM/WB register
- mem_error  out  1  sticky access-timeout flag

## Operation
- mem_op = in_mem_write_enable || load.
- The FSM has two states, IDLE and WAIT.
- **IDLE behaviour:**
  - dmem_req = mem_op, driven combinationally from in_*.
  - dmem_we = in_mem_write_enable.
  - dmem_addr = in_mem_addr; dmem_wdata = in_mem_data.
  - If mem_op && !dmem_ack: latch addr, wdata, we into request registers and go to WAIT.
- **WAIT behaviour:**
  - dmem_* are driven from the latched registers; dmem_req=1.
  - On dmem_ack: return to IDLE.
- stall = mem_op && !dmem_ack, in either state.
- **MEM/WB register update:**
  - If stall: load a bubble (out_reg_write_enable=0, out_wb_res_mux=0). Data fields hold.
  - Otherwise: copy the in_* fields. out_mem_rdata takes dmem_rdata when a load completes, else holds.
- **Branch redirect:**
  - branch_taken = in_branch_taken && !stall.
  - branch_addr = in_branch_addr.
  - Both are combinational, for one cycle.
- **Forwarding:**
  - fwd_data = in_next_pc (zero-extended) for `WB_RES_PC.
  - fwd_data = in_imm for `WB_RES_IMM.
  - fwd_data = in_alu_res otherwise.
  - Load data is never forwarded; hazard detection inserts the load-use bubble.
- A store never writes the register file through this stage.

## Timing
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All out_* registers, request registers, mem_error and timeout counter clear to 0.
  - dmem_req drops immediately. An outstanding access is abandoned; a late dmem_ack is ignored.
- With a zero-wait memory (ack in the same cycle as req): no stall, and load data reaches out_mem_rdata one cycle after the instruction enters MEM.
- With an N-cycle-wait memory: stall is high for N cycles, and the instruction retires to MEM/WB on the ack edge.
- dmem_addr, dmem_wdata and dmem_we stay stable from the first req cycle until ack.
- in_branch_taken only accompanies non-memory instructions, so a redirect and a stall never coincide.
- A WB bubble is emitted on every stalled cycle; exactly one valid MEM/WB entry is produced per instruction.

## Configuration
- MEM_STAGE_TIMEOUT_EN defined:
  - An 8-bit+ counter clears on entry to WAIT and increments in WAIT.
  - When the count reaches TIMEOUT_CYCLES without ack: FSM returns to IDLE, stall drops, and mem_error sets and stays set until reset.
  - The instruction retires with out_reg_write_enable=0, and the store is dropped.
- MEM_STAGE_TIMEOUT_EN undefined:
  - No counter is built and mem_error is tied to 0.
  - WAIT persists until dmem_ack.

## Test plan
- Reset mid-WAIT: assert rst=0 with a load outstanding → dmem_req=0, stall=0 and all outputs 0 immediately; a late dmem_ack after release leaves out_mem_rdata=0.
- Zero-wait store (ack tied 1): in_mem_addr=0x10, in_mem_data=0xDEADBEEF → one cycle of dmem_req=1, dmem_we=1, stall=0, out_reg_write_enable=0.
- 3-wait load: addr 0x20, dmem_rdata=0x12345678 with ack on the 4th cycle → stall high for 3 cycles, 3 WB bubbles, then out_mem_rdata=0x12345678 with out_reg_write_enable=1 and out_reg_dest preserved.
- Branch: in_branch_taken=1, in_branch_addr=0x40 → branch_taken=1 and branch_addr=0x40 for one cycle, stall=0.
- Forwarding: in_wb_res_mux=`WB_RES_IMM, in_imm=0x7 → fwd_data=0x7; `WB_RES_ALU with in_alu_res=0x55 → fwd_data=0x55.
- MEM_STAGE_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ack never raised → stall falls after 4 WAIT cycles, mem_error=1 and held, load retired with out_reg_write_enable=0.
